param_direct_mapped_cache: RTL and testbench

Parametrised successor to the fixed-geometry direct-mapped data cache. It is a read-only, direct-mapped cache with generic address, data, index and block-size widths. Misses are served by an explicit multi-beat fill handshake to backing memory, and the block keeps hit and access statistics plus a sequential flush mode. It sits between the requesting controller (start/done handshake) and the main memory model.

---
 rtl/param_direct_mapped_cache.sv | 171 +++++++++++++++++
 tb/tb_param_direct_mapped_cache.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_direct_mapped_cache.sv
// Read-only direct-mapped cache with generic geometry, multi-beat fill from backing memory,
// saturating hit/access statistics and a sequential invalidate-all flush.
module param_direct_mapped_cache #(
  parameter int unsigned ADDR_W   = 15,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned INDEX_W  = 10,
  parameter int unsigned OFFSET_W = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              flush,
  input  logic [ADDR_W-1:0] address,
  output logic              done,
  output logic [DATA_W-1:0] outData,
  output logic              hit,
  output logic [CNT_W-1:0]  hitNum,
  output logic [CNT_W-1:0]  accessNum,
  output logic              memReq,
  output logic [ADDR_W-1:0] memAddr,
  input  logic              memValid,
  input  logic [DATA_W-1:0] memData
);

  localparam int unsigned TagW  = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned Lines = 2 ** INDEX_W;
  localparam int unsigned Words = 2 ** OFFSET_W;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StFill,
    StRespond,
    StFlush
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [OFFSET_W-1:0] beat_q;
  logic [INDEX_W-1:0]  flush_idx_q;
  logic [Lines-1:0]    valid_q;
  logic                done_q;
  logic                hit_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [CNT_W-1:0]    hit_num_q;
  logic [CNT_W-1:0]    acc_num_q;
  logic                mem_req_q;
  logic [ADDR_W-1:0]   mem_addr_q;

  // Storage arrays carry no reset; the valid bits alone qualify their contents.
  logic [TagW-1:0]   tag_q  [Lines];
  logic [DATA_W-1:0] data_q [Lines * Words];

  logic [TagW-1:0]     req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [OFFSET_W-1:0] req_off;
  logic                lookup_hit;
  logic [DATA_W-1:0]   rd_word;
  logic                last_beat;
  logic                fill_we;
  logic [DATA_W-1:0]   fill_word;

  always_comb begin
    req_tag    = addr_q[ADDR_W-1 -: TagW];
    req_idx    = addr_q[OFFSET_W +: INDEX_W];
    req_off    = addr_q[OFFSET_W-1:0];
    lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    rd_word    = data_q[{req_idx, req_off}];
    last_beat  = (beat_q == {OFFSET_W{1'b1}});
    fill_we    = (state_q == StFill) && memValid;
    // The requested word is either already stored or is arriving on this final beat.
    fill_word  = (req_off == {OFFSET_W{1'b1}}) ? memData : rd_word;
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[{req_idx, beat_q}] <= memData;
      if (last_beat) begin
        tag_q[req_idx] <= req_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      beat_q      <= '0;
      flush_idx_q <= '0;
      valid_q     <= '0;
      done_q      <= 1'b0;
      hit_q       <= 1'b0;
      out_data_q  <= '0;
      hit_num_q   <= '0;
      acc_num_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (flush) begin
            flush_idx_q <= '0;
            state_q     <= StFlush;
          end else if (start) begin
            addr_q  <= address;
            state_q <= StLookup;
          end
        end
        StLookup: begin
          if (acc_num_q != {CNT_W{1'b1}}) begin
            acc_num_q <= acc_num_q + CNT_W'(1);
          end
          if (lookup_hit) begin
            if (hit_num_q != {CNT_W{1'b1}}) begin
              hit_num_q <= hit_num_q + CNT_W'(1);
            end
            out_data_q <= rd_word;
            hit_q      <= 1'b1;
            done_q     <= 1'b1;
            state_q    <= StRespond;
          end else begin
            // Line is being overwritten, so it must not hit until the fill completes.
            valid_q[req_idx] <= 1'b0;
            beat_q           <= '0;
            mem_req_q        <= 1'b1;
            mem_addr_q       <= {req_tag, req_idx, {OFFSET_W{1'b0}}};
            state_q          <= StFill;
          end
        end
        StFill: begin
          if (memValid) begin
            beat_q <= beat_q + OFFSET_W'(1);
            if (last_beat) begin
              valid_q[req_idx] <= 1'b1;
              out_data_q       <= fill_word;
              hit_q            <= 1'b0;
              mem_req_q        <= 1'b0;
              done_q           <= 1'b1;
              state_q          <= StRespond;
            end
          end
        end
        StFlush: begin
          valid_q[flush_idx_q] <= 1'b0;
          flush_idx_q          <= flush_idx_q + INDEX_W'(1);
          if (flush_idx_q == {INDEX_W{1'b1}}) begin
            done_q  <= 1'b1;
            state_q <= StRespond;
          end
        end
        StRespond: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign done      = done_q;
  assign outData   = out_data_q;
  assign hit       = hit_q;
  assign hitNum    = hit_num_q;
  assign accessNum = acc_num_q;
  assign memReq    = mem_req_q;
  assign memAddr   = mem_addr_q;

endmodule

// File: tb/tb_param_direct_mapped_cache.sv
// Bench for param_direct_mapped_cache: random backing memory, array-based line model,
// saturating counter model, scenario tasks run in sequence.
module tb_param_direct_mapped_cache;

  localparam int AW    = 15;
  localparam int DW    = 32;
  localparam int LINES = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] address = '0;
  logic          done;
  logic [DW-1:0] outData;
  logic          hit;
  logic [3:0]    hitNum;
  logic [3:0]    accessNum;
  logic          memReq;
  logic [AW-1:0] memAddr;
  logic          memValid = 1'b0;
  logic [DW-1:0] memData = '0;

  param_direct_mapped_cache #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .INDEX_W (10),
    .OFFSET_W(2),
    .CNT_W   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .flush    (flush),
    .address  (address),
    .done     (done),
    .outData  (outData),
    .hit      (hit),
    .hitNum   (hitNum),
    .accessNum(accessNum),
    .memReq   (memReq),
    .memAddr  (memAddr),
    .memValid (memValid),
    .memData  (memData)
  );

  always #5 clk = ~clk;

  // Reference model: backing memory, per-line valid/tag, saturating counters.
  logic [DW-1:0] mem [32768];
  bit            valid_m [LINES];
  int            tag_m [LINES];
  logic [3:0]    hit_m;
  logic [3:0]    acc_m;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) valid_m[i] = 1'b0;
    hit_m = '0;
    acc_m = '0;
  endtask

  // One access; the model decides hit or miss and the bench plays memory on a miss.
  task automatic do_access(input logic [AW-1:0] a, input int gmin, input int gmax,
                           input string nm);
    int idx, tg, base, gap;
    bit exp_hit;
    idx     = (int'(a) / 4) % LINES;
    tg      = int'(a) / 4096;
    base    = int'(a) - (int'(a) % 4);
    exp_hit = valid_m[idx] && (tag_m[idx] == tg);
    if (acc_m != 4'hF) acc_m = acc_m + 4'd1;
    if (exp_hit && hit_m != 4'hF) hit_m = hit_m + 4'd1;

    @(negedge clk);
    start   = 1'b1;
    address = a;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s lookup_done: got %b want 0", nm, done);
    end
    if (!exp_hit) begin
      @(negedge clk);
      n_checks++;
      if (memReq !== 1'b1 || memAddr !== AW'(base)) begin
        n_fail++;
        $display("FAIL %s fill_req: memReq=%b memAddr=%h want 1 %h", nm, memReq, memAddr,
                 AW'(base));
      end
      for (int b = 0; b < 4; b++) begin
        gap = $urandom_range(gmax, gmin);
        repeat (gap) begin
          memValid = 1'b0;
          memData  = $urandom;
          @(negedge clk);
        end
        memValid = 1'b1;
        memData  = mem[base + b];
        @(negedge clk);
        memValid = 1'b0;
        if (b < 3) begin
          n_checks++;
          if (done !== 1'b0 || memReq !== 1'b1) begin
            n_fail++;
            $display("FAIL %s beat%0d: done=%b memReq=%b want 0 1", nm, b, done, memReq);
          end
        end
      end
      valid_m[idx] = 1'b1;
      tag_m[idx]   = tg;
    end else begin
      @(negedge clk);
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done: got %b want 1", nm, done);
    end
    n_checks++;
    if (outData !== mem[a] || hit !== exp_hit) begin
      n_fail++;
      $display("FAIL %s data: outData=%h hit=%b want %h %b", nm, outData, hit, mem[a], exp_hit);
    end
    n_checks++;
    if (hitNum !== hit_m || accessNum !== acc_m || memReq !== 1'b0) begin
      n_fail++;
      $display("FAIL %s stats: hitNum=%0d accessNum=%0d memReq=%b want %0d %0d 0", nm, hitNum,
               accessNum, memReq, hit_m, acc_m);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_pulse: got %b want 0", nm, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || hit !== 1'b0 || memReq !== 1'b0 || outData !== '0 ||
        memAddr !== '0 || hitNum !== '0 || accessNum !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: done=%b hit=%b memReq=%b outData=%h memAddr=%h hn=%0d an=%0d want all 0",
               done, hit, memReq, outData, memAddr, hitNum, accessNum);
    end
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_cold_miss_and_hit();
    do_access(15'h0005, 0, 0, "cold_miss");
    do_access(15'h0007, 0, 0, "hit_after_fill");
    n_checks++;
    if (hitNum !== 4'd1 || accessNum !== 4'd2) begin
      n_fail++;
      $display("FAIL first_stats: hitNum=%0d accessNum=%0d want 1 2", hitNum, accessNum);
    end
  endtask

  task automatic test_conflict();
    logic [3:0] hits_before;
    hits_before = hitNum;
    do_access(15'h1004, 3, 3, "conflict_tag1");
    do_access(15'h0004, 0, 2, "conflict_tag0");
    n_checks++;
    if (hitNum !== hits_before) begin
      n_fail++;
      $display("FAIL conflict_hits: hitNum=%0d want %0d", hitNum, hits_before);
    end
  endtask

  task automatic test_flush();
    logic [DW-1:0] od;
    logic          hd;
    int            cnt;
    od = outData;
    hd = hit;
    @(negedge clk);
    flush   = 1'b1;
    start   = 1'b1;
    address = 15'h0004;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    cnt   = 1;
    while (done !== 1'b1 && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (cnt != LINES + 1) begin
      n_fail++;
      $display("FAIL flush_latency: got %0d cycles want %0d", cnt, LINES + 1);
    end
    n_checks++;
    if (outData !== od || hit !== hd || hitNum !== hit_m || accessNum !== acc_m) begin
      n_fail++;
      $display("FAIL flush_hold: outData=%h hit=%b hn=%0d an=%0d want %h %b %0d %0d", outData,
               hit, hitNum, accessNum, od, hd, hit_m, acc_m);
    end
    for (int i = 0; i < LINES; i++) valid_m[i] = 1'b0;
    @(negedge clk);
    do_access(15'h0004, 0, 1, "after_flush");
  endtask

  task automatic test_reset_mid_fill();
    logic [AW-1:0] a;
    a = 15'h2348;
    @(negedge clk);
    start   = 1'b1;
    address = a;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      memValid = 1'b1;
      memData  = mem[(int'(a) & ~3) + b];
      @(negedge clk);
    end
    memValid = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (memReq !== 1'b0 || done !== 1'b0 || accessNum !== '0 || hitNum !== '0 ||
        memAddr !== '0 || outData !== '0) begin
      n_fail++;
      $display("FAIL midfill_reset: memReq=%b done=%b an=%0d hn=%0d memAddr=%h outData=%h want all 0",
               memReq, done, accessNum, hitNum, memAddr, outData);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    do_access(a, 0, 1, "refill_after_reset");
  endtask

  task automatic test_saturation();
    do_access(15'h3000, 0, 0, "sat_fill");
    for (int i = 0; i < 20; i++) begin
      do_access(AW'(15'h3000 + $urandom_range(3, 0)), 0, 0, "sat_hit");
    end
    n_checks++;
    if (hitNum !== 4'd15 || accessNum !== 4'd15) begin
      n_fail++;
      $display("FAIL saturation: hitNum=%0d accessNum=%0d want 15 15", hitNum, accessNum);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int i = 0; i < 80; i++) begin
      // Stray memory beats while idle must be ignored.
      memValid = 1'b1;
      memData  = $urandom;
      @(negedge clk);
      memValid = 1'b0;
      a = AW'($urandom_range(3, 0) * 4096 + $urandom_range(7, 0) * 4 + $urandom_range(3, 0));
      do_access(a, 0, 2, "random");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = $urandom;
    test_reset();
    test_cold_miss_and_hit();
    test_conflict();
    test_flush();
    test_reset_mid_fill();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
